sr_flag_arbiter: RTL and testbench
==================================

# sr_flag_arbiter

Round-robin controller that shares a bank of clocked SR flip-flop flags among several requesters. Each accepted request is converted into a single-cycle set or reset strobe on exactly one flag, so the bank never sees S=R=1 (the invalid state). An optional verify stage reads the flag's Q back one cycle later and records mismatches in a sticky error. The block sits between the requesting agents and the flag bank.

## Interface
- NREQ, 4, number of requesters (2..8)
- NFLAG, 8, number of SR flags in the bank (1..64)
- FLAG_W, $clog2(NFLAG) (min 1), flag index width
- clk  in  1  rising-edge clock, shared with the flag bank
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_op  in  NREQ  per requester: 1 = set, 0 = reset
- req_idx  in  NREQ*FLAG_W  per requester target flag, requester i at bits [i*FLAG_W +: FLAG_W]
- req_ready  out  NREQ  one-hot grant; handshake completes when valid & ready at a clk edge
- flag_s  out  NFLAG  set strobes to the bank
- flag_r  out  NFLAG  reset strobes to the bank
- flag_q  in  NFLAG  Q outputs fed back from the bank
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse in the cycle an operation completes
- err_clr  in  1  clears err
- err  out  1  sticky error flag
- err_idx  out  FLAG_W  index of the most recent erroring operation

## Operation
- FSM states: IDLE, DRIVE, VERIFY. VERIFY exists only with the macro defined (see Configuration).
- IDLE:
  - If any req_valid bit is set, pick a grantee g by round-robin. Search starts at ptr and wraps modulo NREQ.
  - req_ready[g]=1 combinationally in that cycle. All other ready bits are 0, and all ready bits are 0 outside IDLE.
  - At the edge: latch op, idx and g; set ptr=(g+1) mod NREQ; go to DRIVE.
- DRIVE:
  - If idx<NFLAG: op=1 drives flag_s[idx]=1, op=0 drives flag_r[idx]=1, for exactly one cycle. All other strobe bits are 0.
  - If idx>=NFLAG: no strobe is driven; at the edge set err=1 and err_idx=idx.
  - Next state is VERIFY (macro defined) or IDLE with done=1 in DRIVE (macro undefined).
- VERIFY:
  - done=1 for this cycle.
  - For a valid idx, if flag_q[idx]!=op, at the edge set err=1 and err_idx=idx.
  - Next state is IDLE.
- Invariant: flag_s & flag_r == 0 at all times, and at most one strobe bit is high in any cycle.
- Requesters hold valid, op and idx stable until granted. Deasserting valid before grant is legal; that request is dropped.
- Conflicts: opposite ops from different requesters on the same flag are serialized in round-robin order. The flag ends in the state of the last-granted op.
- err_clr: clears err at the edge; err_idx holds its value. If err_clr coincides with a new error, err stays 1 and err_idx updates.
- Reset values: state=IDLE, ptr=0, req_ready=0, flag_s=0, flag_r=0, busy=0, done=0, err=0, err_idx=0.
- Reset mid-operation: all state returns to IDLE at that edge and any pending strobe is cancelled. The granted request is lost and is not replayed. The flag bank itself is not reset by this block.

## Timing
- Grant cycle T (IDLE): strobe in T+1 (DRIVE).
- Flag bank updates at the end of T+1. Q is valid in T+2.
- Macro defined: VERIFY and done in T+2, err visible in T+3, earliest next grant in T+3. Throughput is one operation per 3 cycles.
- Macro undefined: done in T+1, earliest next grant in T+2. Throughput is one operation per 2 cycles.
- busy=1 in DRIVE and VERIFY. busy=0 in the grant cycle.
- All outputs are registered or decoded from registered state, except req_ready, which is combinational from req_valid, ptr and state.

## Configuration
- SR_FLAG_ARB_VERIFY_EN defined: VERIFY state present; Q readback compared; mismatch sets err.
- SR_FLAG_ARB_VERIFY_EN undefined: no VERIFY state; flag_q is ignored; err is set only by out-of-range idx; 2-cycle operation.

## Test plan
- Reset, then single request: rst 1 for 2 cycles, then req_valid=0001, op=1, idx=3 -> ready=0001 in T, flag_s=0x08 in T+1 only, done in T+2 (verify build), flag_q[3]=1, err=0.
- Round-robin fairness: all four requesters valid continuously, each with a distinct idx -> grants in order 0,1,2,3,0, one grant every 3 cycles; no requester is granted twice before the others.
- Conflict on one flag: req0 set idx=5 and req1 reset idx=5, both valid, ptr=0 -> flag_s[5] pulse, then flag_r[5] pulse; final flag_q[5]=0; flag_s & flag_r == 0 every cycle.
- Verify mismatch: bench model holds flag_q[2]=0 against a set on idx=2 -> err=1 in T+3 and err_idx=2. Then err_clr=1 -> err=0 next cycle, err_idx stays 2.
- Out-of-range index with NFLAG=6 and idx=7 -> no strobe asserted, err=1, err_idx=7, done still pulses.
- Reset mid-operation: assert rst in the DRIVE cycle -> flag_s=0 and flag_r=0 the next cycle, state IDLE, ptr=0, busy=0, done never pulses for that request.

Source files
------------

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin arbiter that turns requests into one-cycle SR strobes on a flag bank.
// Define SR_FLAG_ARB_VERIFY_EN to add a Q-readback VERIFY cycle that flags mismatches in err_o.
module sr_flag_arbiter #(
   parameter int NREQ   = 4,
   parameter int NFLAG  = 8,
   parameter int FLAG_W = (NFLAG > 1) ? $clog2(NFLAG) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NREQ-1:0]        req_valid_i,
   input  logic [NREQ-1:0]        req_op_i,
   input  logic [NREQ*FLAG_W-1:0] req_idx_i,
   output logic [NREQ-1:0]        req_ready_o,
   output logic [NFLAG-1:0]       flag_s_o,
   output logic [NFLAG-1:0]       flag_r_o,
   input  logic [NFLAG-1:0]       flag_q_i,
   output logic                   busy_o,
   output logic                   done_o,
   input  logic                   err_clr_i,
   output logic                   err_o,
   output logic [FLAG_W-1:0]      err_idx_o
);
   // state     | meaning
   // ST_IDLE   | waiting for a request; grant is combinational
   // ST_DRIVE  | one-cycle set or reset strobe on the latched flag
   // ST_VERIFY | compare flag Q against the latched op (verify build only)
   localparam int REQ_W = $clog2(NREQ);

`ifdef SR_FLAG_ARB_VERIFY_EN
   typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_VERIFY} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_DRIVE} state_t;
`endif

   state_t             state_q, state_d;
   logic [REQ_W-1:0]   ptr_q, ptr_d;
   logic               op_q, op_d;
   logic [FLAG_W-1:0]  idx_q, idx_d;
   logic               err_q, err_d;
   logic [FLAG_W-1:0]  err_idx_q, err_idx_d;

   logic               gnt_found;
   logic [REQ_W-1:0]   gnt_idx;
   logic [REQ_W-1:0]   cand;
   logic               sel_op;
   logic [FLAG_W-1:0]  sel_idx;
   logic               idx_ok;
   logic               new_err;

   // Search starts at ptr and wraps, so the last grantee has lowest priority.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = REQ_W'((int'(ptr_q) + i) % NREQ);
         if (!gnt_found && req_valid_i[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_op  = 1'b0;
      sel_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (REQ_W'(i) == gnt_idx) begin
            sel_op  = req_op_i[i];
            sel_idx = req_idx_i[i*FLAG_W +: FLAG_W];
         end
      end
   end

   assign idx_ok = ({1'b0, idx_q} < (FLAG_W+1)'(NFLAG));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      op_d    = op_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_found) begin
               op_d    = sel_op;
               idx_d   = sel_idx;
               ptr_d   = (gnt_idx == REQ_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
               state_d = ST_DRIVE;
            end
         end
`ifdef SR_FLAG_ARB_VERIFY_EN
         ST_DRIVE:  state_d = ST_VERIFY;
         ST_VERIFY: state_d = ST_IDLE;
`else
         ST_DRIVE:  state_d = ST_IDLE;
`endif
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      new_err = 1'b0;
      if (state_q == ST_DRIVE && !idx_ok) new_err = 1'b1;
`ifdef SR_FLAG_ARB_VERIFY_EN
      if (state_q == ST_VERIFY && idx_ok && (flag_q_i[idx_q] != op_q)) new_err = 1'b1;
`endif
      err_d     = err_q;
      err_idx_d = err_idx_q;
      if (err_clr_i) err_d = 1'b0;
      // A new error wins over a simultaneous clear.
      if (new_err) begin
         err_d     = 1'b1;
         err_idx_d = idx_q;
      end
   end

`ifndef SR_FLAG_ARB_VERIFY_EN
   logic unused_flag_q;
   assign unused_flag_q = ^flag_q_i;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         op_q      <= 1'b0;
         idx_q     <= '0;
         err_q     <= 1'b0;
         err_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         op_q      <= op_d;
         idx_q     <= idx_d;
         err_q     <= err_d;
         err_idx_q <= err_idx_d;
      end
   end

   always_comb begin
      flag_s_o = '0;
      flag_r_o = '0;
      if (state_q == ST_DRIVE && idx_ok) begin
         if (op_q) flag_s_o = NFLAG'(1) << idx_q;
         else      flag_r_o = NFLAG'(1) << idx_q;
      end
   end

   assign req_ready_o = (state_q == ST_IDLE && gnt_found) ? (NREQ'(1) << gnt_idx) : '0;
   assign busy_o      = (state_q != ST_IDLE);
`ifdef SR_FLAG_ARB_VERIFY_EN
   assign done_o      = (state_q == ST_VERIFY);
`else
   assign done_o      = (state_q == ST_DRIVE);
`endif
   assign err_o       = err_q;
   assign err_idx_o   = err_idx_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: scoreboard of expected grants/strobes plus a behavioural flag bank.
// Adapts its latency expectations to SR_FLAG_ARB_VERIFY_EN.
module tb_sr_flag_arbiter;
   localparam int NREQ   = 4;
   localparam int NFLAG  = 6;
   localparam int FLAG_W = 3;
`ifdef SR_FLAG_ARB_VERIFY_EN
   localparam int LAT = 2;
   localparam bit VER = 1'b1;
`else
   localparam int LAT = 1;
   localparam bit VER = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_op;
   logic [NREQ*FLAG_W-1:0] req_idx;
   logic [NREQ-1:0]        req_ready;
   logic [NFLAG-1:0]       flag_s, flag_r, flag_q;
   logic                   busy, done, err_clr, err;
   logic [FLAG_W-1:0]      err_idx;

   logic [NFLAG-1:0]       bank = '0;
   logic [NFLAG-1:0]       stuck;
   assign flag_q = bank & ~stuck;

   always #5 clk = ~clk;

   sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .FLAG_W(FLAG_W)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_op_i(req_op), .req_idx_i(req_idx),
      .req_ready_o(req_ready),
      .flag_s_o(flag_s), .flag_r_o(flag_r), .flag_q_i(flag_q),
      .busy_o(busy), .done_o(done),
      .err_clr_i(err_clr), .err_o(err), .err_idx_o(err_idx)
   );

   typedef struct {int g; bit op; int idx;} exp_t;
   exp_t sb_q[$];

   int n_chk = 0;
   int n_pass = 0;
   bit hold_valid;

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
   endtask

   // Flag bank: captures strobes mid-cycle, well before the DUT samples Q.
   always @(negedge clk) if (!rst) bank <= (bank | flag_s) & ~flag_r;

   int               cyc = 0;
   int               done_at = -1;
   int               last_gnt = 0;
   bit               last_hold = 1'b0;
   bit               strobe_pend = 1'b0;
   logic [NFLAG-1:0] exp_s, exp_r;
   exp_t             e;

   always @(negedge clk) begin
      if (rst) begin
         strobe_pend = 1'b0;
         done_at     = -1;
      end else begin
         if (strobe_pend) begin
            chk_eq("strobe_s", flag_s, exp_s);
            chk_eq("strobe_r", flag_r, exp_r);
            chk_eq("busy_drive", busy, 1);
            strobe_pend = 1'b0;
         end else if ((flag_s | flag_r) != '0) begin
            chk_eq("stray_strobe", flag_s | flag_r, 0);
         end
         if ((flag_s & flag_r) != '0) chk_eq("s_and_r", flag_s & flag_r, 0);
         if (done || cyc == done_at) chk_eq("done", done, cyc == done_at);
         if (req_ready != '0) begin
            chk_eq("busy_gnt", busy, 0);
            if (hold_valid && last_hold) chk_eq("gnt_gap", cyc - last_gnt, LAT + 1);
            last_gnt  = cyc;
            last_hold = hold_valid;
            if (sb_q.size() == 0) begin
               chk_eq("gnt_unexpected", req_ready, 0);
            end else begin
               e = sb_q.pop_front();
               chk_eq("gnt", req_ready, 1 << e.g);
               exp_s = '0;
               exp_r = '0;
               if (e.idx < NFLAG) begin
                  if (e.op) exp_s[e.idx] = 1'b1;
                  else      exp_r[e.idx] = 1'b1;
               end
               strobe_pend = 1'b1;
               done_at     = cyc + LAT;
            end
         end
      end
      cyc++;
   end

   task automatic push_op(input int g, input bit op, input int idx);
      exp_t x;
      x.g = g; x.op = op; x.idx = idx;
      sb_q.push_back(x);
   endtask

   task automatic set_req(input int i, input bit op, input int idx);
      req_op[i] = op;
      req_idx[i*FLAG_W +: FLAG_W] = FLAG_W'(idx);
      req_valid[i] = 1'b1;
   endtask

   task automatic tick();
      logic [NREQ-1:0] g;
      @(negedge clk);
      g = req_ready;
      @(posedge clk);
      #1;
      if (!hold_valid) req_valid = req_valid & ~g;
   endtask

   task automatic wait_drain(input int max_cyc);
      int n;
      n = 0;
      while ((sb_q.size() != 0 || busy) && n < max_cyc) begin
         if (hold_valid && sb_q.size() == 0) begin
            req_valid  = '0;
            hold_valid = 1'b0;
         end
         tick();
         n++;
      end
      if (sb_q.size() != 0 || busy) chk_eq("drain_timeout", sb_q.size() + 32'(busy), 0);
   endtask

   initial begin
      req_valid = '0; req_op = '0; req_idx = '0;
      err_clr = 1'b0; hold_valid = 1'b0; stuck = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk_eq("rst_ready", req_ready, 0);
      chk_eq("rst_s", flag_s, 0);
      chk_eq("rst_r", flag_r, 0);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_done", done, 0);
      chk_eq("rst_err", err, 0);
      chk_eq("rst_err_idx", err_idx, 0);

      // single set on flag 3 from requester 0
      push_op(0, 1'b1, 3);
      set_req(0, 1'b1, 3);
      wait_drain(20);
      chk_eq("single_q3", flag_q[3], 1);
      chk_eq("single_err", err, 0);

      // all requesters held valid: rotation starts at ptr=1
      hold_valid = 1'b1;
      push_op(1, 1'b1, 1);
      push_op(2, 1'b1, 4);
      push_op(3, 1'b1, 5);
      push_op(0, 1'b1, 0);
      push_op(1, 1'b1, 1);
      set_req(0, 1'b1, 0);
      set_req(1, 1'b1, 1);
      set_req(2, 1'b1, 4);
      set_req(3, 1'b1, 5);
      wait_drain(40);
      chk_eq("rr_bank", flag_q, 6'h3b);

      // flag 2 stuck low against a set
      stuck[2] = 1'b1;
      push_op(2, 1'b1, 2);
      set_req(2, 1'b1, 2);
      wait_drain(20);
      chk_eq("vfy_err", err, VER);
      chk_eq("vfy_err_idx", err_idx, VER ? 2 : 0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk_eq("clr_err", err, 0);
      chk_eq("clr_err_idx", err_idx, VER ? 2 : 0);
      stuck = '0;

      // out-of-range index 7 with NFLAG=6
      push_op(3, 1'b1, 7);
      set_req(3, 1'b1, 7);
      wait_drain(20);
      chk_eq("oor_err", err, 1);
      chk_eq("oor_err_idx", err_idx, 7);
      chk_eq("oor_bank", flag_q, 6'h3f);

      // conflicting set/reset on flag 5, ptr=0
      push_op(0, 1'b1, 5);
      push_op(1, 1'b0, 5);
      set_req(0, 1'b1, 5);
      set_req(1, 1'b0, 5);
      wait_drain(20);
      chk_eq("conflict_q5", flag_q[5], 0);
      chk_eq("conflict_bank", flag_q, 6'h1f);

      // reset during DRIVE of requester 2 (ptr would become 3)
      push_op(2, 1'b0, 1);
      set_req(2, 1'b0, 1);
      tick();
      chk_eq("mid_in_drive", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_eq("mid_s", flag_s, 0);
      chk_eq("mid_r", flag_r, 0);
      chk_eq("mid_busy", busy, 0);
      chk_eq("mid_err", err, 0);
      // ptr back to 0: requester 1 must win over 3
      push_op(1, 1'b1, 2);
      push_op(3, 1'b1, 4);
      set_req(1, 1'b1, 2);
      set_req(3, 1'b1, 4);
      wait_drain(20);
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got %0d checks expected completion", n_chk);
      $fatal(1);
   end
endmodule
